// File: rtl/sens_stim_gen.sv
// Multi-channel sensor-sample generator: drives data/valid with const, ramp, LFSR or channel-tagged sequences.
// Define STIM_CHECKSUM_EN to add chk_o, a running sum of accepted samples.
module sens_stim_gen #(
  parameter int                DWIDTH     = 8,
  parameter int                NCH        = 4,
  parameter int                GAPW       = 16,
  parameter int                VAL_CYCLES = 3,
  parameter logic [DWIDTH-1:0] LFSR_TAPS  = 8'hB8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [1:0]              mode_i,
  input  logic [DWIDTH-1:0]       seed_i,
  input  logic [GAPW-1:0]         gap_i,
  input  logic [15:0]             count_i,
  input  logic                    sens_ready_i,
  output logic [DWIDTH-1:0]       sens_data_o,
  output logic                    sens_val_o,
  output logic [$clog2(NCH)-1:0]  sens_ch_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef STIM_CHECKSUM_EN
  ,
  output logic [DWIDTH-1:0]       chk_o
`endif
);

  localparam int CHW = $clog2(NCH);
  localparam int HW  = (VAL_CYCLES > 1) ? $clog2(VAL_CYCLES) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(VAL_CYCLES - 1);
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DWIDTH-1:0] seed_q, seed_d;
  logic [GAPW-1:0]   gap_q, gap_d;
  logic [15:0]       count_q, count_d;
  logic [DWIDTH-1:0] ramp_q, ramp_d;
  logic [DWIDTH-1:0] lfsr_q, lfsr_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [GAPW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]       smp_q, smp_d;
  logic [15:0]       smp_inc;
  logic [DWIDTH-1:0] sample;
  logic [DWIDTH-1:0] lfsr_next;
`ifdef STIM_CHECKSUM_EN
  logic [DWIDTH-1:0] chk_q, chk_d;
`endif

  always_comb begin
    case (mode_q)
      2'd1:    sample = ramp_q;
      2'd2:    sample = lfsr_q;
      2'd3:    sample = {ch_q, ramp_q[DWIDTH-CHW-1:0]};
      default: sample = seed_q;
    endcase
  end

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign smp_inc   = smp_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    seed_d    = seed_q;
    gap_d     = gap_q;
    count_d   = count_q;
    ramp_d    = ramp_q;
    lfsr_d    = lfsr_q;
    ch_d      = ch_q;
    hold_d    = hold_q;
    gap_cnt_d = gap_cnt_q;
    smp_d     = smp_q;
`ifdef STIM_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        // stop_i beats start_i when both arrive in the same cycle
        if (start_i && !stop_i) begin
          state_d   = S_DRIVE;
          mode_d    = mode_i;
          seed_d    = seed_i;
          gap_d     = gap_i;
          count_d   = count_i;
          ramp_d    = seed_i;
          lfsr_d    = (seed_i == '0) ? DWIDTH'(1) : seed_i;
          ch_d      = '0;
          hold_d    = '0;
          gap_cnt_d = '0;
          smp_d     = '0;
`ifdef STIM_CHECKSUM_EN
          chk_d     = '0;
`endif
        end
      end
      S_DRIVE: begin
        if (stop_i) begin
          state_d = S_DONE;
        end else if (sens_ready_i) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            smp_d  = smp_inc;
            ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            ramp_d = ramp_q + 1'b1;
            lfsr_d = lfsr_next;
`ifdef STIM_CHECKSUM_EN
            chk_d  = chk_q + sample;
`endif
            if (count_q != 16'd0 && smp_inc == count_q) begin
              state_d = S_DONE;
            end else if (gap_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (stop_i) begin
          state_d = S_DONE;
        end else if (gap_cnt_q == gap_q - GAPW'(1)) begin
          state_d   = S_DRIVE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      seed_q    <= '0;
      gap_q     <= '0;
      count_q   <= '0;
      ramp_q    <= '0;
      lfsr_q    <= '0;
      ch_q      <= '0;
      hold_q    <= '0;
      gap_cnt_q <= '0;
      smp_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      gap_q     <= gap_d;
      count_q   <= count_d;
      ramp_q    <= ramp_d;
      lfsr_q    <= lfsr_d;
      ch_q      <= ch_d;
      hold_q    <= hold_d;
      gap_cnt_q <= gap_cnt_d;
      smp_q     <= smp_d;
    end
  end

`ifdef STIM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst) chk_q <= '0;
    else      chk_q <= chk_d;
  end
  assign chk_o = chk_q;
`endif

  assign sens_data_o = sample;
  assign sens_ch_o   = ch_q;
  assign sens_val_o  = (state_q == S_DRIVE);
  assign busy_o      = (state_q == S_DRIVE) || (state_q == S_GAP);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_sens_stim_gen.sv
// Self-checking bench for sens_stim_gen: table-driven runs, hand-written corner sequences,
// and randomized runs checked against a sample-sequence model.
module tb_sens_stim_gen;
  localparam int DW   = 8;
  localparam int NCH  = 4;
  localparam int VALC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [7:0]  seed_i = '0;
  logic [15:0] gap_i = '0;
  logic [15:0] count_i = '0;
  logic        sens_ready_i = 1'b0;
  logic [7:0]  sens_data_o;
  logic        sens_val_o;
  logic [1:0]  sens_ch_o;
  logic        busy_o;
  logic        done_o;
`ifdef STIM_CHECKSUM_EN
  logic [7:0]  chk_o;
`endif

  int n_vec = 0;
  int n_bad = 0;

  sens_stim_gen #(.DWIDTH(DW), .NCH(NCH), .GAPW(16), .VAL_CYCLES(VALC), .LFSR_TAPS(8'hB8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
    .seed_i(seed_i), .gap_i(gap_i), .count_i(count_i), .sens_ready_i(sens_ready_i),
    .sens_data_o(sens_data_o), .sens_val_o(sens_val_o), .sens_ch_o(sens_ch_o),
    .busy_o(busy_o), .done_o(done_o)
`ifdef STIM_CHECKSUM_EN
    , .chk_o(chk_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic [15:0] gap;
    logic [15:0] count;
    logic        ready;
    logic        e_val;
    logic [7:0]  e_data;
    logic [1:0]  e_ch;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // n-th sample of a sequence, computed straight from the sequence definitions
  function automatic logic [7:0] model_sample(input logic [1:0] mode, input logic [7:0] seed, input int n);
    logic [7:0] ramp;
    logic [7:0] x;
    ramp = seed + 8'(n);
    x    = (seed == 8'h00) ? 8'h01 : seed;
    case (mode)
      2'd0: return seed;
      2'd1: return ramp;
      2'd2: begin
        for (int i = 0; i < n; i++) x = x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
        return x;
      end
      default: return {2'(n % NCH), ramp[5:0]};
    endcase
  endfunction

  function automatic vec_t mk_vec(input logic start, input logic [1:0] mode, input logic [7:0] seed,
                                  input logic [15:0] gap, input logic [15:0] count, input logic e_val,
                                  input logic [7:0] e_data, input logic [1:0] e_ch, input logic e_busy,
                                  input logic e_done);
    vec_t v;
    v.start = start; v.stop = 1'b0; v.mode = mode; v.seed = seed; v.gap = gap; v.count = count;
    v.ready = 1'b1; v.e_val = e_val; v.e_data = e_data; v.e_ch = e_ch; v.e_busy = e_busy;
    v.e_done = e_done;
    return v;
  endfunction

  // Expected cycle-by-cycle outputs of one full run with sink always ready
  task automatic add_run(input logic [1:0] mode, input logic [7:0] seed, input logic [15:0] gap,
                         input logic [15:0] count);
    int k = 0;
    for (int s = 0; s < int'(count); s++) begin
      for (int h = 0; h < VALC; h++) begin
        if (k == 0)
          tbl.push_back(mk_vec(1'b1, mode, seed, gap, count, 1'b1, model_sample(mode, seed, s),
                               2'(s % NCH), 1'b1, 1'b0));
        else
          tbl.push_back(mk_vec(k == 2, 2'($urandom), 8'($urandom), 16'($urandom_range(9)),
                               16'($urandom_range(9)), 1'b1, model_sample(mode, seed, s),
                               2'(s % NCH), 1'b1, 1'b0));
        k++;
      end
      if (s < int'(count) - 1)
        for (int g = 0; g < int'(gap); g++) begin
          tbl.push_back(mk_vec(1'b0, 2'($urandom), 8'($urandom), 16'd0, 16'd0, 1'b0, 8'h00, 2'd0,
                               1'b1, 1'b0));
          k++;
        end
    end
    tbl.push_back(mk_vec(1'b0, 2'd0, 8'h00, 16'd0, 16'd0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1));
    tbl.push_back(mk_vec(1'b0, 2'd0, 8'h00, 16'd0, 16'd0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0));
  endtask

  task automatic apply_stimulus(input vec_t v);
    start_i = v.start; stop_i = v.stop; mode_i = v.mode; seed_i = v.seed;
    gap_i = v.gap; count_i = v.count; sens_ready_i = v.ready;
    @(negedge clk);
  endtask

  // Randomized run: watch the sink handshake, then compare against the model
  task automatic run_seq(input logic [1:0] mode, input logic [7:0] seed, input logic [15:0] gap,
                         input logic [15:0] count, input int ready_pct, input bit glitch);
    logic [7:0] got_d[$];
    logic [1:0] got_c[$];
    int held = 0, low_cnt = 0, done_at = -1, last_rec = -1;
    bit pending = 0, rdy;
    logic [7:0] sum = 8'h00;
    start_i = 1'b1; stop_i = 1'b0; mode_i = mode; seed_i = seed; gap_i = gap; count_i = count;
    @(negedge clk);
    start_i = 1'b0;
    mode_i = 2'($urandom); seed_i = 8'($urandom); gap_i = 16'($urandom_range(5));
    count_i = 16'($urandom_range(5));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done_o) begin
        done_at = cyc;
        break;
      end
      if (pending) begin
        if (sens_val_o) begin
          check_output("rs.gap_len", low_cnt, gap);
          pending = 0;
        end else begin
          low_cnt++;
        end
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (glitch && cyc == 1) begin
        start_i = 1'b1; mode_i = 2'($urandom); seed_i = 8'($urandom); count_i = 16'd9;
      end
      if (sens_val_o && rdy) begin
        held++;
        if (held == VALC) begin
          got_d.push_back(sens_data_o);
          got_c.push_back(sens_ch_o);
          last_rec = cyc;
          held = 0;
          if (got_d.size() < int'(count)) begin
            pending = 1;
            low_cnt = 0;
          end
        end
      end
      sens_ready_i = rdy;
      @(negedge clk);
      start_i = 1'b0;
    end
    check_output("rs.timeout", done_at >= 0, 1);
    check_output("rs.count", got_d.size(), count);
    check_output("rs.done_time", done_at, last_rec + 1);
    check_output("rs.done_val_busy", {sens_val_o, busy_o}, 2'b00);
    for (int i = 0; i < got_d.size() && i < int'(count); i++) begin
      check_output($sformatf("rs.data[%0d]", i), got_d[i], model_sample(mode, seed, i));
      check_output($sformatf("rs.ch[%0d]", i), got_c[i], i % NCH);
    end
    for (int i = 0; i < int'(count); i++) sum = sum + model_sample(mode, seed, i);
`ifdef STIM_CHECKSUM_EN
    check_output("rs.chk", chk_o, sum);
`endif
    @(negedge clk);
    check_output("rs.done_pulse", {done_o, busy_o}, 2'b00);
  endtask

  initial begin
    logic [7:0] t5_exp[5];
    int         pat[8];
    t5_exp[0] = 8'h3E; t5_exp[1] = 8'h7F; t5_exp[2] = 8'h80; t5_exp[3] = 8'hC1; t5_exp[4] = 8'h02;
    pat = '{1, 0, 0, 0, 0, 0, 1, 1};

    // Reset held low with inputs toggling
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start_i = 1'($urandom); stop_i = 1'($urandom); mode_i = 2'($urandom);
      seed_i = 8'($urandom); gap_i = 16'($urandom_range(3)); count_i = 16'($urandom_range(4));
      sens_ready_i = 1'($urandom);
      @(negedge clk);
      check_output("reset_outs", {sens_val_o, sens_data_o, sens_ch_o, busy_o, done_o}, 0);
    end
    start_i = 1'b0; stop_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_output("post_reset", {sens_val_o, sens_data_o, sens_ch_o, busy_o, done_o}, 0);

    // Table-driven full runs: ramp with gaps, then LFSR seeded with zero
    add_run(2'd1, 8'h10, 16'd2, 16'd4);
    add_run(2'd2, 8'h00, 16'd0, 16'd3);
    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i]);
      check_output($sformatf("tbl[%0d].val", i), sens_val_o, tbl[i].e_val);
      check_output($sformatf("tbl[%0d].busy", i), busy_o, tbl[i].e_busy);
      check_output($sformatf("tbl[%0d].done", i), done_o, tbl[i].e_done);
      if (tbl[i].e_val) begin
        check_output($sformatf("tbl[%0d].data", i), sens_data_o, tbl[i].e_data);
        check_output($sformatf("tbl[%0d].ch", i), sens_ch_o, tbl[i].e_ch);
      end
    end
`ifdef STIM_CHECKSUM_EN
    check_output("lfsr_chk", chk_o, 8'h15);
`endif

    // Backpressure: ready low five cycles stretches the single sample to eight valid cycles
    start_i = 1'b1; mode_i = 2'd1; seed_i = 8'h40; gap_i = 16'd0; count_i = 16'd1; sens_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("bp.val[%0d]", i), sens_val_o, 1'b1);
      check_output($sformatf("bp.data[%0d]", i), sens_data_o, 8'h40);
      sens_ready_i = 1'(pat[i]);
      @(negedge clk);
    end
    check_output("bp.done", {done_o, sens_val_o}, 2'b10);
    sens_ready_i = 1'b1;
    @(negedge clk);

    // Continuous tagged run with channel and ramp wrap, aborted during a gap
    start_i = 1'b1; mode_i = 2'd3; seed_i = 8'hFE; gap_i = 16'd1; count_i = 16'd0;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int h = 0; h < VALC; h++) begin
        check_output($sformatf("tag.val[%0d]", k), sens_val_o, 1'b1);
        check_output($sformatf("tag.data[%0d]", k), sens_data_o, t5_exp[k]);
        check_output($sformatf("tag.ch[%0d]", k), sens_ch_o, k % NCH);
        @(negedge clk);
      end
      check_output($sformatf("tag.gap[%0d]", k), {sens_val_o, busy_o}, 2'b01);
      if (k == 4) stop_i = 1'b1;
      @(negedge clk);
    end
    stop_i = 1'b0;
    check_output("tag.stop_done", {done_o, sens_val_o, busy_o}, 3'b100);
    @(negedge clk);
    check_output("tag.idle", {done_o, busy_o}, 2'b00);

    // start and stop together in IDLE: nothing happens
    start_i = 1'b1; stop_i = 1'b1; mode_i = 2'd1; seed_i = 8'h55; count_i = 16'd2;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
    check_output("ss.stay_idle", {sens_val_o, busy_o, done_o}, 3'b000);
    @(negedge clk);
    check_output("ss.no_done", {sens_val_o, busy_o, done_o}, 3'b000);

    // start while busy is ignored
    run_seq(2'd1, 8'h20, 16'd0, 16'd2, 100, 1'b1);

    // Reset asserted mid-run
    start_i = 1'b1; mode_i = 2'd1; seed_i = 8'h33; gap_i = 16'd0; count_i = 16'd0; sens_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst", {sens_val_o, sens_data_o, sens_ch_o, busy_o, done_o}, 0);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst.after", {sens_val_o, sens_data_o, sens_ch_o, busy_o, done_o}, 0);

    for (int t = 0; t < 12; t++)
      run_seq(2'($urandom), 8'($urandom), 16'($urandom_range(3)), 16'($urandom_range(6, 1)),
              $urandom_range(100, 60), (t % 3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
